// File: rtl/cpu_interrupt_arbiter.sv
// cpu_interrupt_arbiter
// Collects level interrupt requests as rising-edge pending bits and filters them
// through a software-written enable mask. It presents one granted source at a
// time to the CSR unit. The IDLE -> GRANT -> HOLDOFF handshake keeps the grant
// stable until the trap is acknowledged. After the acknowledge, one quiet cycle
// lets the CSR unit retire the trap.
//
// Build option: define ROUND_ROBIN_EN for rotating priority. The search starts
// one past the last acknowledged source. Without it, the lowest index wins and
// no pointer register exists.
module cpu_interrupt_arbiter #(
    parameter int SOURCES = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [SOURCES-1:0]         i_irq,
    input  logic                       i_cfg_we,
    input  logic [SOURCES-1:0]         i_cfg_wdata,
    input  logic                       i_ack,
    output logic                       o_interrupt,
    output logic [$clog2(SOURCES)-1:0] o_source,
    output logic [SOURCES-1:0]         o_pending,
    output logic [SOURCES-1:0]         o_cfg_mask
);

    localparam int SW = $clog2(SOURCES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SOURCES-1:0] irq_q_r;
    logic [SOURCES-1:0] pending_r;
    logic [SOURCES-1:0] mask_r;
    logic               interrupt_r;
    logic [SW-1:0]      source_r;

    logic [SOURCES-1:0] rise_s;
    logic [SOURCES-1:0] eligible_s;
    logic [SOURCES-1:0] clear_s;
    logic [SOURCES-1:0] pending_nxt_s;
    logic [SW-1:0]      winner_s;
    logic [SW-1:0]      source_nxt_s;
    logic               interrupt_nxt_s;
    logic               ack_take_s;

`ifdef ROUND_ROBIN_EN
    logic [SW-1:0]      rr_ptr_r;

    // Rotating search: first eligible bit at or after (last + 1), wrapping.
    function automatic logic [SW-1:0] pick_round_robin(
        input logic [SOURCES-1:0] req,
        input logic [SW-1:0]      last
    );
        logic [SW-1:0] win;
        logic [SW-1:0] idx;
        logic          found;
        int            pos;
        win   = {SW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < SOURCES; k++) begin
            pos = int'(last) + 1 + k;
            if (pos >= SOURCES) begin
                pos = pos - SOURCES;
            end
            idx = SW'(pos);
            if (req[idx] && !found) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction
`else
    // Fixed priority: lowest set index wins.
    function automatic logic [SW-1:0] pick_fixed(
        input logic [SOURCES-1:0] req
    );
        logic [SW-1:0] win;
        logic          found;
        win   = {SW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < SOURCES; i++) begin
            if (req[i] && !found) begin
                win   = SW'(i);
                found = 1'b1;
            end
        end
        return win;
    endfunction
`endif

    assign rise_s     = i_irq & ~irq_q_r;
    assign eligible_s = pending_r & mask_r;

`ifdef ROUND_ROBIN_EN
    assign winner_s = pick_round_robin(eligible_s, rr_ptr_r);
`else
    assign winner_s = pick_fixed(eligible_s);
`endif

    // Grant handshake: next state, next request level and latched source.
    always_comb begin
        state_nxt_s     = state_r;
        interrupt_nxt_s = 1'b0;
        source_nxt_s    = source_r;
        ack_take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (|eligible_s) begin
                    state_nxt_s     = GRANT;
                    interrupt_nxt_s = 1'b1;
                    source_nxt_s    = winner_s;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            GRANT: begin
                if (i_ack) begin
                    // Acknowledge takes precedence over a mask withdrawal.
                    state_nxt_s = HOLDOFF;
                    ack_take_s  = 1'b1;
                end else if (!mask_r[source_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s     = GRANT;
                    interrupt_nxt_s = 1'b1;
                end
            end
            HOLDOFF: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pending update: acknowledged bit clears, but a fresh edge on it survives.
    always_comb begin
        clear_s = {SOURCES{1'b0}};
        if (ack_take_s) begin
            clear_s[source_r] = 1'b1;
        end else begin
            clear_s = {SOURCES{1'b0}};
        end
        pending_nxt_s = (pending_r & ~clear_s) | rise_s;
    end

    // State, request, source, pending, mask and edge-detect registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= IDLE;
            interrupt_r <= 1'b0;
            source_r    <= {SW{1'b0}};
            pending_r   <= {SOURCES{1'b0}};
            mask_r      <= {SOURCES{1'b0}};
            irq_q_r     <= {SOURCES{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            interrupt_r <= interrupt_nxt_s;
            source_r    <= source_nxt_s;
            pending_r   <= pending_nxt_s;
            irq_q_r     <= i_irq;
            if (i_cfg_we) begin
                mask_r <= i_cfg_wdata;
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    // Round-robin pointer advances only when a grant is acknowledged.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rr_ptr_r <= {SW{1'b0}};
        end else if (ack_take_s) begin
            rr_ptr_r <= source_r;
        end
    end
`endif

    assign o_interrupt = interrupt_r;
    assign o_source    = source_r;
    assign o_pending   = pending_r;
    assign o_cfg_mask  = mask_r;

endmodule

// File: tb/tb_cpu_interrupt_arbiter.sv
// Directed testbench for cpu_interrupt_arbiter (SOURCES = 4).
// Expectations follow the fixed-priority build unless ROUND_ROBIN_EN is defined.
module tb_cpu_interrupt_arbiter;

    logic       i_clock;
    logic       i_reset;
    logic [3:0] i_irq;
    logic       i_cfg_we;
    logic [3:0] i_cfg_wdata;
    logic       i_ack;
    logic       o_interrupt;
    logic [1:0] o_source;
    logic [3:0] o_pending;
    logic [3:0] o_cfg_mask;

    int n_cmp;
    int n_bad;

    cpu_interrupt_arbiter #(.SOURCES(4)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_irq       (i_irq),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_wdata (i_cfg_wdata),
        .i_ack       (i_ack),
        .o_interrupt (o_interrupt),
        .o_source    (o_source),
        .o_pending   (o_pending),
        .o_cfg_mask  (o_cfg_mask)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        i_cfg_we    = 1'b1;
        i_cfg_wdata = m;
        tick();
        i_cfg_we    = 1'b0;
        i_cfg_wdata = 4'b0000;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        i_irq = v;
        tick();
        i_irq = 4'b0000;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_int: got %0b expected 0", o_interrupt); end
        n_cmp++; if (o_source !== 2'd0) begin n_bad++; $display("FAIL reset_src: got %0d expected 0", o_source); end
        n_cmp++; if (o_pending !== 4'b0000) begin n_bad++; $display("FAIL reset_pending: got %b expected 0000", o_pending); end
        n_cmp++; if (o_cfg_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_mask: got %b expected 0000", o_cfg_mask); end
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_grant();
        write_mask(4'b0010);
        n_cmp++; if (o_cfg_mask !== 4'b0010) begin n_bad++; $display("FAIL basic_mask: got %b expected 0010", o_cfg_mask); end
        pulse_irq(4'b0010);
        n_cmp++; if (o_pending !== 4'b0010) begin n_bad++; $display("FAIL basic_pending_set: got %b expected 0010", o_pending); end
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL basic_int_early: got %0b expected 0", o_interrupt); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL basic_int_grant: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== 2'd1) begin n_bad++; $display("FAIL basic_src: got %0d expected 1", o_source); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL basic_int_hold: got %0b expected 1", o_interrupt); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        n_cmp++; if (o_pending !== 4'b0000) begin n_bad++; $display("FAIL basic_pending_clr: got %b expected 0000", o_pending); end
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL basic_int_holdoff: got %0b expected 0", o_interrupt); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL basic_int_idle: got %0b expected 0", o_interrupt); end
    endtask

    task automatic test_priority();
        logic [1:0] first_src;
        logic [1:0] second_src;
        logic [3:0] left_pending;
`ifdef ROUND_ROBIN_EN
        first_src    = 2'd3;
        second_src   = 2'd1;
        left_pending = 4'b0010;
`else
        first_src    = 2'd1;
        second_src   = 2'd3;
        left_pending = 4'b1000;
`endif
        write_mask(4'b1111);
        pulse_irq(4'b1010);
        n_cmp++; if (o_pending !== 4'b1010) begin n_bad++; $display("FAIL prio_pending: got %b expected 1010", o_pending); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL prio_int1: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== first_src) begin n_bad++; $display("FAIL prio_src1: got %0d expected %0d", o_source, first_src); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        n_cmp++; if (o_pending !== left_pending) begin n_bad++; $display("FAIL prio_pending_left: got %b expected %b", o_pending, left_pending); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL prio_int_gap: got %0b expected 0", o_interrupt); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL prio_int2: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== second_src) begin n_bad++; $display("FAIL prio_src2: got %0d expected %0d", o_source, second_src); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        n_cmp++; if (o_pending !== 4'b0000) begin n_bad++; $display("FAIL prio_pending_end: got %b expected 0000", o_pending); end
        tick();
    endtask

    task automatic test_masked_pending();
        write_mask(4'b0000);
        pulse_irq(4'b0100);
        n_cmp++; if (o_pending !== 4'b0100) begin n_bad++; $display("FAIL mask_pending: got %b expected 0100", o_pending); end
        tick();
        tick();
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL mask_int_off: got %0b expected 0", o_interrupt); end
        n_cmp++; if (o_pending !== 4'b0100) begin n_bad++; $display("FAIL mask_pending_kept: got %b expected 0100", o_pending); end
        write_mask(4'b0100);
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL mask_int_same_edge: got %0b expected 0", o_interrupt); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL mask_int_on: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== 2'd2) begin n_bad++; $display("FAIL mask_src: got %0d expected 2", o_source); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        write_mask(4'b0001);
        pulse_irq(4'b0001);
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL wd_int_grant: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== 2'd0) begin n_bad++; $display("FAIL wd_src: got %0d expected 0", o_source); end
        write_mask(4'b0000);
        tick();
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL wd_int_drop: got %0b expected 0", o_interrupt); end
        n_cmp++; if (o_pending !== 4'b0001) begin n_bad++; $display("FAIL wd_pending: got %b expected 0001", o_pending); end
        // Acknowledge while idle must not touch the pending bit.
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        n_cmp++; if (o_pending !== 4'b0001) begin n_bad++; $display("FAIL wd_idle_ack: got %b expected 0001", o_pending); end
        write_mask(4'b0001);
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL wd_regrant: got %0b expected 1", o_interrupt); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        pulse_irq(4'b0001);
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL b2b_int_grant: got %0b expected 1", o_interrupt); end
        i_ack = 1'b1;
        i_irq = 4'b0001;
        tick();
        i_ack = 1'b0;
        i_irq = 4'b0000;
        n_cmp++; if (o_pending !== 4'b0001) begin n_bad++; $display("FAIL b2b_edge_wins: got %b expected 0001", o_pending); end
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL b2b_holdoff: got %0b expected 0", o_interrupt); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %0b expected 0", o_interrupt); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL b2b_regrant: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== 2'd0) begin n_bad++; $display("FAIL b2b_src: got %0d expected 0", o_source); end
        // Acknowledge together with a mask clear: the acknowledge wins.
        i_ack       = 1'b1;
        i_cfg_we    = 1'b1;
        i_cfg_wdata = 4'b0000;
        tick();
        i_ack       = 1'b0;
        i_cfg_we    = 1'b0;
        n_cmp++; if (o_pending !== 4'b0000) begin n_bad++; $display("FAIL ackmask_pending: got %b expected 0000", o_pending); end
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL ackmask_int: got %0b expected 0", o_interrupt); end
        n_cmp++; if (o_cfg_mask !== 4'b0000) begin n_bad++; $display("FAIL ackmask_mask: got %b expected 0000", o_cfg_mask); end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        write_mask(4'b0010);
        pulse_irq(4'b0010);
        tick();
        n_cmp++; if (o_source !== 2'd1) begin n_bad++; $display("FAIL rst_pre_src: got %0d expected 1", o_source); end
        #2;
        i_reset = 1'b0;
        #1;
        n_cmp++; if (o_interrupt !== 1'b0) begin n_bad++; $display("FAIL rst_async_int: got %0b expected 0", o_interrupt); end
        n_cmp++; if (o_source !== 2'd0) begin n_bad++; $display("FAIL rst_async_src: got %0d expected 0", o_source); end
        n_cmp++; if (o_pending !== 4'b0000) begin n_bad++; $display("FAIL rst_async_pending: got %b expected 0000", o_pending); end
        n_cmp++; if (o_cfg_mask !== 4'b0000) begin n_bad++; $display("FAIL rst_async_mask: got %b expected 0000", o_cfg_mask); end
        i_irq = 4'b0001;
        tick();
        i_reset     = 1'b1;
        i_cfg_we    = 1'b1;
        i_cfg_wdata = 4'b0001;
        tick();
        i_cfg_we    = 1'b0;
        n_cmp++; if (o_pending !== 4'b0001) begin n_bad++; $display("FAIL rst_release_pending: got %b expected 0001", o_pending); end
        n_cmp++; if (o_cfg_mask !== 4'b0001) begin n_bad++; $display("FAIL rst_release_mask: got %b expected 0001", o_cfg_mask); end
        tick();
        n_cmp++; if (o_interrupt !== 1'b1) begin n_bad++; $display("FAIL rst_release_int: got %0b expected 1", o_interrupt); end
        n_cmp++; if (o_source !== 2'd0) begin n_bad++; $display("FAIL rst_release_src: got %0d expected 0", o_source); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        i_reset     = 1'b0;
        i_irq       = 4'b0000;
        i_cfg_we    = 1'b0;
        i_cfg_wdata = 4'b0000;
        i_ack       = 1'b0;
        test_reset();
        test_basic_grant();
        test_priority();
        test_masked_pending();
        test_withdraw();
        test_back_to_back();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
